slope_recon: RTL and testbench

SLOPE_RECON -- requirements
Module: slope_recon

---
 rtl/slope_recon.sv | 131 +++++++++++++
 tb/tb_slope_recon.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/slope_recon.sv
// slope_recon: slope-delta reconstructor.
// Integrates +step / -step on the posen / negen strobes, tracks the current
// slope direction and run length, and captures the turning-point value on
// every direction reversal (peak on RISE->FALL, valley on FALL->RISE).
// The direction register is visible on the 'state' port.
//
// Build option: define SLOPE_RECON_SAT_EN to clamp overflow/underflow to the
// signed range and raise a sticky 'sat' flag. Without it results wrap modulo
// 2^WIDTH and 'sat' is tied to 0.
module slope_recon #(
    parameter int WIDTH = 16,
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] init,
    input  logic             posen,
    input  logic             negen,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] dataout,
    output logic [1:0]       state,
    output logic [RUN_W-1:0] run,
    output logic [WIDTH-1:0] peak,
    output logic [WIDTH-1:0] valley,
    output logic             ext_valid,
    output logic             err,
    output logic             sat
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RISE = 2'b01,
        FALL = 2'b10
    } dir_t;

`ifdef SLOPE_RECON_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    dir_t             dir_q;
    logic             sat_q;
    logic [WIDTH:0]   sum;
    logic             ovf_hi;
    logic             ovf_lo;
    logic [WIDTH-1:0] next_data;
    logic             stepping;
    dir_t             new_dir;

    assign state    = dir_q;
    assign sat      = SAT_EN ? sat_q : 1'b0;
    assign stepping = en & (posen ^ negen);
    assign new_dir  = posen ? RISE : FALL;

    // WIDTH+1-bit signed add/subtract; the top two bits disagreeing means
    // the true result left the WIDTH-bit signed range.
    always_comb begin
        sum       = '0;
        next_data = '0;
        if (posen) begin
            sum = {dataout[WIDTH-1], dataout} + {1'b0, step};
        end else begin
            sum = {dataout[WIDTH-1], dataout} - {1'b0, step};
        end
        ovf_hi = ~sum[WIDTH] & sum[WIDTH-1];
        ovf_lo = sum[WIDTH] & ~sum[WIDTH-1];
        if (SAT_EN && ovf_hi) begin
            next_data = MAX_POS;
        end else if (SAT_EN && ovf_lo) begin
            next_data = MIN_NEG;
        end else begin
            next_data = sum[WIDTH-1:0];
        end
    end

    // Direction FSM plus all registered outputs; load outranks en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q     <= IDLE;
            dataout   <= '0;
            run       <= '0;
            peak      <= '0;
            valley    <= '0;
            ext_valid <= 1'b0;
            err       <= 1'b0;
            sat_q     <= 1'b0;
        end else if (load) begin
            dir_q     <= IDLE;
            dataout   <= init;
            run       <= '0;
            ext_valid <= 1'b0;
            err       <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            ext_valid <= 1'b0;
            if (en && posen && negen) begin
                // Conflicting strobes: no movement, remember the fault.
                err <= 1'b1;
            end else if (stepping) begin
                dataout <= next_data;
                dir_q   <= new_dir;
                if (SAT_EN && (ovf_hi || ovf_lo)) begin
                    sat_q <= 1'b1;
                end
                if (new_dir == dir_q) begin
                    if (run != {RUN_W{1'b1}}) begin
                        run <= run + 1'b1;
                    end
                end else begin
                    run <= {{(RUN_W-1){1'b0}}, 1'b1};
                end
                // Capture the pre-step value only on a true reversal;
                // leaving IDLE is not a turning point.
                if (dir_q == RISE && new_dir == FALL) begin
                    peak      <= dataout;
                    ext_valid <= 1'b1;
                end else if (dir_q == FALL && new_dir == RISE) begin
                    valley    <= dataout;
                    ext_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_slope_recon.sv
// tb_slope_recon: directed, table-driven bench for slope_recon (WIDTH=16).
// Expected values are hand-computed; the SLOPE_RECON_SAT_EN macro selects
// the clamping or wrapping expectations for the overflow vectors.
module tb_slope_recon;

    localparam int W = 16;
    localparam int R = 8;

`ifdef SLOPE_RECON_SAT_EN
    localparam logic [15:0] E12  = 16'h7FFF;
    localparam logic [15:0] E13  = 16'h7EFF;
    localparam logic [15:0] PK13 = 16'h7FFF;
    localparam logic [15:0] E15  = 16'h8000;
    localparam logic        S12  = 1'b1;
    localparam logic        S15  = 1'b1;
`else
    localparam logic [15:0] E12  = 16'h8100;
    localparam logic [15:0] E13  = 16'h8000;
    localparam logic [15:0] PK13 = 16'h8100;
    localparam logic [15:0] E15  = 16'h7F00;
    localparam logic        S12  = 1'b0;
    localparam logic        S15  = 1'b0;
`endif

    // clock / reset
    logic         clk = 1'b0;
    logic         reset;
    logic         en, load, posen, negen;
    logic [W-1:0] init, step;
    logic [W-1:0] dataout, peak, valley;
    logic [1:0]   state;
    logic [R-1:0] run;
    logic         ext_valid, err, sat;

    always #5 clk = ~clk;

    slope_recon #(.WIDTH(W), .RUN_W(R)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .init(init),
        .posen(posen), .negen(negen), .step(step), .dataout(dataout),
        .state(state), .run(run), .peak(peak), .valley(valley),
        .ext_valid(ext_valid), .err(err), .sat(sat)
    );

    typedef struct {
        logic        load;
        logic        en;
        logic        posen;
        logic        negen;
        logic [15:0] init;
        logic [15:0] step;
        logic [15:0] d;
        logic [1:0]  st;
        logic [7:0]  run;
        logic [15:0] pk;
        logic [15:0] vl;
        logic        ev;
        logic        err;
        logic        sat;
    } vec_t;

    vec_t vecs[17];
    int   total = 0;
    int   bad   = 0;

    // scoreboard compare
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".dataout"}, dataout, v.d);
        check({tag, ".state"}, {14'd0, state}, {14'd0, v.st});
        check({tag, ".run"}, {8'd0, run}, {8'd0, v.run});
        check({tag, ".peak"}, peak, v.pk);
        check({tag, ".valley"}, valley, v.vl);
        check({tag, ".ext_valid"}, {15'd0, ext_valid}, {15'd0, v.ev});
        check({tag, ".err"}, {15'd0, err}, {15'd0, v.err});
        check({tag, ".sat"}, {15'd0, sat}, {15'd0, v.sat});
    endtask

    // driver
    task automatic drive(input logic l, input logic e, input logic p, input logic n,
                         input logic [15:0] i, input logic [15:0] s);
        load = l; en = e; posen = p; negen = n; init = i; step = s;
    endtask

    initial begin
        //                  ld en  p  n  init      step      dataout   st  run pk        vl        ev err sat
        vecs[0]  = '{1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[1]  = '{0, 1, 1, 0, 16'h0000, 16'h0100, 16'h0100, 1, 1, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[2]  = '{0, 1, 1, 0, 16'h0000, 16'h0100, 16'h0200, 1, 2, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[3]  = '{0, 1, 1, 0, 16'h0000, 16'h0100, 16'h0300, 1, 3, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 1, 16'h0000, 16'h0100, 16'h0200, 2, 1, 16'h0300, 16'h0000, 1, 0, 0};
        vecs[5]  = '{0, 0, 1, 0, 16'h0000, 16'h0100, 16'h0200, 2, 1, 16'h0300, 16'h0000, 0, 0, 0};
        vecs[6]  = '{0, 1, 0, 1, 16'h0000, 16'h0100, 16'h0100, 2, 2, 16'h0300, 16'h0000, 0, 0, 0};
        vecs[7]  = '{0, 1, 1, 0, 16'h0000, 16'h0080, 16'h0180, 1, 1, 16'h0300, 16'h0100, 1, 0, 0};
        vecs[8]  = '{0, 1, 1, 1, 16'h0000, 16'h0080, 16'h0180, 1, 1, 16'h0300, 16'h0100, 0, 1, 0};
        vecs[9]  = '{0, 1, 1, 0, 16'h0000, 16'h0080, 16'h0200, 1, 2, 16'h0300, 16'h0100, 0, 1, 0};
        vecs[10] = '{0, 1, 0, 0, 16'h0000, 16'h0080, 16'h0200, 1, 2, 16'h0300, 16'h0100, 0, 1, 0};
        vecs[11] = '{1, 1, 1, 0, 16'h7F00, 16'h0080, 16'h7F00, 0, 0, 16'h0300, 16'h0100, 0, 0, 0};
        vecs[12] = '{0, 1, 1, 0, 16'h0000, 16'h0200, E12,      1, 1, 16'h0300, 16'h0100, 0, 0, S12};
        vecs[13] = '{0, 1, 0, 1, 16'h0000, 16'h0100, E13,      2, 1, PK13,     16'h0100, 1, 0, S12};
        vecs[14] = '{1, 0, 0, 0, 16'h8100, 16'h0000, 16'h8100, 0, 0, PK13,     16'h0100, 0, 0, 0};
        vecs[15] = '{0, 1, 0, 1, 16'h0000, 16'h0200, E15,      2, 1, PK13,     16'h0100, 0, 0, S15};
        vecs[16] = '{0, 1, 0, 1, 16'h0000, 16'h0000, E15,      2, 2, PK13,     16'h0100, 0, 0, S15};

        // reset state
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", '{0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0});
        reset = 1'b0;

        // table-driven vectors, one clock each
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].load, vecs[i].en, vecs[i].posen, vecs[i].negen,
                  vecs[i].init, vecs[i].step);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // run counter saturates at 255; leaving IDLE toward FALL pulses nothing
        drive(1, 0, 0, 0, 16'h0000, 16'h0);
        @(posedge clk); #1;
        drive(0, 1, 0, 1, 16'h0000, 16'h0);
        @(posedge clk); #1;
        check("idle_fall.ext_valid", {15'd0, ext_valid}, 16'd0);
        check("idle_fall.run", {8'd0, run}, 16'd1);
        check("idle_fall.state", {14'd0, state}, 16'd2);
        repeat (259) @(posedge clk);
        #1;
        check("run_sat.run", {8'd0, run}, 16'd255);
        check("run_sat.dataout", dataout, 16'h0000);

        // asynchronous reset mid-ramp, asserted between clock edges
        drive(1, 0, 0, 0, 16'h1000, 16'h0);
        @(posedge clk); #1;
        drive(0, 1, 1, 0, 16'h0000, 16'h0010);
        repeat (3) @(posedge clk);
        #1;
        check("ramp.dataout", dataout, 16'h1030);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", '{0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0});
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, 1, 0, 16'h0000, 16'h0010);
        @(posedge clk); #1;
        check("post_reset.dataout", dataout, 16'h0010);
        check("post_reset.state", {14'd0, state}, 16'd1);
        check("post_reset.run", {8'd0, run}, 16'd1);
        check("post_reset.ext_valid", {15'd0, ext_valid}, 16'd0);

        drive(0, 0, 0, 0, 16'h0, 16'h0);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
